// File: rtl/msg_comm_rx.sv
// msg_comm_rx -- serial message frame receiver.
//
// Receives frames of N payload bytes followed by one CRC-8 byte. The bits
// arrive MSB first while the frame strobe is high. Payload bytes are emitted
// with a one-byte lag, so the final byte of a frame is never emitted and is
// compared against the running CRC instead.
//
// Ports:
//   clk_sys_i          single clock; link launched on fall, sampled on rise
//   rst_n_i            asynchronous active-low reset
//   msg_rx_fsx_i       frame strobe, high for the whole frame
//   msg_rx_i           serial data, MSB of each byte first
//   msg_rx_data_o      received payload byte
//   msg_rx_data_vld_o  one-cycle strobe qualifying msg_rx_data_o
//   msg_rx_byte_num_o  payload byte count of the last completed frame
//   msg_rx_done_o      one-cycle end-of-frame strobe
//   msg_rx_crc_err_o   CRC mismatch flag for the last frame
//   msg_rx_frame_err_o framing / overflow flag for the last frame
module msg_comm_rx #(
  parameter logic [15:0] MAX_BYTE_NUM = 16'd1024,
  parameter logic [7:0]  CRC_INIT     = 8'hFF
) (
  input  logic        clk_sys_i,
  input  logic        rst_n_i,
  input  logic        msg_rx_fsx_i,
  input  logic        msg_rx_i,
  output logic [7:0]  msg_rx_data_o,
  output logic        msg_rx_data_vld_o,
  output logic [15:0] msg_rx_byte_num_o,
  output logic        msg_rx_done_o,
  output logic        msg_rx_crc_err_o,
  output logic        msg_rx_frame_err_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        armed;      // FSX has been sampled low since reset
  logic [6:0]  shift;      // the 8th bit completes the byte straight into hold
  logic [7:0]  shift_nxt;
  logic [2:0]  bit_cnt;
  logic [7:0]  hold;
  logic        hold_vld;
  logic [7:0]  crc;
  logic [15:0] byte_cnt;
  logic        ovf;
  logic        start, take, byte_end, frame_err;

  // CRC-8, poly x^8+x^2+x+1, MSB first, one whole byte per call
  function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++)
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  assign shift_nxt = {shift, msg_rx_i};
  // after reset with FSX already high, wait for a low sample before starting
  assign start     = (state == IDLE) && msg_rx_fsx_i && armed;
  assign take      = (state == RECV) && msg_rx_fsx_i;
  assign byte_end  = take && (bit_cnt == 3'd7);
  assign frame_err = (bit_cnt != 3'd0) || !hold_vld || ovf;

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = start ? RECV : IDLE;
      RECV:    state_nxt = msg_rx_fsx_i ? RECV : CHECK;
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      armed              <= 1'b0;
      shift              <= '0;
      bit_cnt            <= '0;
      hold               <= '0;
      hold_vld           <= 1'b0;
      crc                <= CRC_INIT;
      byte_cnt           <= '0;
      ovf                <= 1'b0;
      msg_rx_data_o      <= '0;
      msg_rx_data_vld_o  <= 1'b0;
      msg_rx_byte_num_o  <= '0;
      msg_rx_done_o      <= 1'b0;
      msg_rx_crc_err_o   <= 1'b0;
      msg_rx_frame_err_o <= 1'b0;
    end else begin
      msg_rx_data_vld_o <= 1'b0;
      msg_rx_done_o     <= 1'b0;
      if (!msg_rx_fsx_i) armed <= 1'b1;

      if (start) begin
        // this sample is bit 7 of byte 0
        shift    <= shift_nxt[6:0];
        bit_cnt  <= 3'd1;
        hold_vld <= 1'b0;
        crc      <= CRC_INIT;
        byte_cnt <= '0;
        ovf      <= 1'b0;
      end else if (take) begin
        shift   <= shift_nxt[6:0];
        bit_cnt <= bit_cnt + 3'd1;
        if (byte_end) begin
          hold     <= shift_nxt;
          hold_vld <= 1'b1;
          // a newer byte arrived, so the held one is payload, not CRC
          if (hold_vld) begin
            if (byte_cnt < MAX_BYTE_NUM) begin
              msg_rx_data_o     <= hold;
              msg_rx_data_vld_o <= 1'b1;
              crc               <= crc8_upd(crc, hold);
              byte_cnt          <= byte_cnt + 16'd1;
            end else begin
              ovf <= 1'b1;
            end
          end
        end
      end

      if (state == CHECK) begin
        msg_rx_done_o      <= 1'b1;
        msg_rx_byte_num_o  <= byte_cnt;
        msg_rx_frame_err_o <= frame_err;
        msg_rx_crc_err_o   <= !frame_err && (hold != crc);
      end
    end
  end

endmodule

// File: tb/tb_msg_comm_rx.sv
// Bench for msg_comm_rx: directed frames, a frame-level model that predicts
// the cycle of every payload strobe and done pulse, and a per-cycle compare.
module tb_msg_comm_rx;
  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fsx = 1'b0;
  logic        rx = 1'b0;
  logic [7:0]  data;
  logic        vld;
  logic [15:0] byte_num;
  logic        done;
  logic        crc_err;
  logic        frame_err;

  msg_comm_rx #(.MAX_BYTE_NUM(16'd4), .CRC_INIT(8'hFF)) dut (
    .clk_sys_i(clk), .rst_n_i(rst_n), .msg_rx_fsx_i(fsx), .msg_rx_i(rx),
    .msg_rx_data_o(data), .msg_rx_data_vld_o(vld), .msg_rx_byte_num_o(byte_num),
    .msg_rx_done_o(done), .msg_rx_crc_err_o(crc_err), .msg_rx_frame_err_o(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int nvec = 0, nerr = 0, nvld = 0;

  typedef struct { int c; logic [7:0] d; } vld_ev_t;
  typedef struct { int c; logic [15:0] n; logic ce; logic fe; } done_ev_t;
  vld_ev_t  vq[$];
  done_ev_t dq[$];
  logic [15:0] h_num = '0;
  logic        h_ce = 1'b0, h_fe = 1'b0;
  logic [7:0]  fb [0:15];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // bit-serial CRC-8 (poly 0x07), one data bit at a time, MSB first
  function automatic logic [7:0] crc_model(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r = c;
    for (int i = 7; i >= 0; i--) begin
      logic f = r[7] ^ d[i];
      r = {r[6:0], 1'b0} ^ (f ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  // Predicts every output event for a frame of nb bits whose first bit is
  // driven on the falling edge at cycle st (sampled on the next rise).
  task automatic frame_model(input int st, input int nb);
    int ncomp, emitted, nv;
    logic [7:0] c;
    logic fe, ce;
    ncomp   = nb / 8;
    emitted = (ncomp > 0) ? ncomp - 1 : 0;
    nv      = (emitted > MAXB) ? MAXB : emitted;
    c = 8'hFF;
    for (int k = 0; k < nv; k++) begin
      vq.push_back('{c: st + 8 * k + 16, d: fb[k]});
      c = crc_model(c, fb[k]);
    end
    fe = (nb % 8 != 0) || (ncomp == 0) || (emitted > MAXB);
    ce = !fe && (fb[ncomp - 1] != c);
    dq.push_back('{c: st + nb + 2, n: 16'(nv), ce: ce, fe: fe});
  endtask

  // compare process: every cycle, shortly after the rising edge
  logic ev, ed;
  initial forever begin
    @(posedge clk); #2;
    if (!rst_n) begin
      vq.delete(); dq.delete();
      h_num = '0; h_ce = 1'b0; h_fe = 1'b0;
    end
    ev = (vq.size() > 0) && (vq[0].c == cyc);
    ed = (dq.size() > 0) && (dq[0].c == cyc);
    if (vld) nvld++;
    check("vld", 32'(vld), 32'(ev));
    if (ev) begin
      check("data", 32'(data), 32'(vq[0].d));
      void'(vq.pop_front());
    end
    check("done", 32'(done), 32'(ed));
    if (ed) begin
      h_num = dq[0].n; h_ce = dq[0].ce; h_fe = dq[0].fe;
      void'(dq.pop_front());
    end
    check("byte_num", 32'(byte_num), 32'(h_num));
    check("crc_err", 32'(crc_err), 32'(h_ce));
    check("frame_err", 32'(frame_err), 32'(h_fe));
    if (!rst_n) check("data_rst", 32'(data), 32'd0);
  end

  // rst_at >= 0 pulses reset for two cycles starting at that bit index
  task automatic send(input int nb, input int rst_at);
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      if (i == 0) frame_model(cyc, nb);
      if (i == rst_at) rst_n = 1'b0;
      if (rst_at >= 0 && i == rst_at + 2) rst_n = 1'b1;
      fsx = 1'b1;
      rx  = fb[i / 8][7 - (i % 8)];
    end
    repeat (6) begin
      @(negedge clk);
      fsx = 1'b0; rx = 1'b0;
    end
  endtask

  int v0;
  logic [7:0] c3;
  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // single zero byte; CRC of {00} from seed FF is F3
    check("crc_model_pin", 32'(crc_model(8'hFF, 8'h00)), 32'h0000_00F3);
    fb[0] = 8'h00; fb[1] = 8'hF3;
    send(16, -1);
    check("t1_byte_num", 32'(byte_num), 32'd1);
    check("t1_errs", {30'd0, crc_err, frame_err}, 32'd0);

    // three payload bytes with correct CRC
    fb[0] = 8'h12; fb[1] = 8'h34; fb[2] = 8'h56;
    c3 = crc_model(crc_model(crc_model(8'hFF, 8'h12), 8'h34), 8'h56);
    fb[3] = c3;
    send(32, -1);
    check("t2_byte_num", 32'(byte_num), 32'd3);
    check("t2_errs", {30'd0, crc_err, frame_err}, 32'd0);

    // CRC byte with bit 0 flipped
    fb[3] = c3 ^ 8'h01;
    send(32, -1);
    check("t3_errs", {30'd0, crc_err, frame_err}, 32'd2);

    // 20-bit frame: not a whole number of bytes
    fb[0] = 8'hA5; fb[1] = 8'h5A; fb[2] = 8'hC3;
    send(20, -1);
    check("t4_byte_num", 32'(byte_num), 32'd1);
    check("t4_errs", {30'd0, crc_err, frame_err}, 32'd1);

    // six payload bytes against a limit of four
    for (int k = 0; k < 7; k++) fb[k] = 8'(k + 1);
    v0 = nvld;
    send(56, -1);
    check("t5_vld_count", 32'(nvld - v0), 32'd4);
    check("t5_byte_num", 32'(byte_num), 32'd4);
    check("t5_errs", {30'd0, crc_err, frame_err}, 32'd1);

    // reset during byte 2, FSX stays high across the release
    fb[0] = 8'hDE; fb[1] = 8'hAD; fb[2] = 8'hBE; fb[3] = 8'hEF;
    send(32, 19);
    check("t6_byte_num", 32'(byte_num), 32'd0);
    check("t6_outs", {28'd0, vld, done, crc_err, frame_err}, 32'd0);

    // next good frame after the reset
    fb[0] = 8'h00; fb[1] = 8'hF3;
    send(16, -1);
    check("t7_byte_num", 32'(byte_num), 32'd1);
    check("t7_errs", {30'd0, crc_err, frame_err}, 32'd0);

    check("pending_events", 32'(vq.size() + dq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
